// File: rtl/dac_spi_receiver.sv
// rtl/dac_spi_receiver.sv - receive-side model of the dual 12-bit galvo DAC serial link
//
// Purpose: deserialises 16-bit DAC command words from dac_csn/dac_sclk/dac_mosi,
// keeps per-channel input registers and copies them to the output registers
// while dac_latchn is low.
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   dac_csn/sclk/mosi    serial frame select, clock, data (MSB first), async to clk
//   dac_latchn           output transfer, active low (level-sensitive)
//   out_a/out_b          12-bit output codes (zero while the channel is shut down)
//   active_a/active_b    channel not shut down (SHDN bit)
//   gain_a/gain_b        GA bit (1 = 1x)
//   word_valid/word_data good-frame pulse and last good word
//   frame_error          pulse for a frame whose bit count is not WORD_BITS
module dac_spi_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_BITS   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dac_csn,
  input  logic        dac_sclk,
  input  logic        dac_mosi,
  input  logic        dac_latchn,
  output logic [11:0] out_a,
  output logic [11:0] out_b,
  output logic        active_a,
  output logic        active_b,
  output logic        gain_a,
  output logic        gain_b,
  output logic        word_valid,
  output logic [15:0] word_data,
  output logic        frame_error
);

  localparam logic [4:0]  CNT_MAX  = 5'd17;
  localparam logic [4:0]  CNT_WORD = 5'(WORD_BITS);
  // Channel register layout: [13]=GA, [12]=SHDN, [11:0]=code
  localparam logic [13:0] CH_RST   = 14'h2000;

  // Synchronisers reset to idle line levels so reset release never looks like an edge
  logic [SYNC_STAGES-1:0] csn_sync_q, sclk_sync_q, mosi_sync_q, latchn_sync_q;
  logic                   csn_prev_q, sclk_prev_q;
  logic                   csn_s, sclk_s, mosi_s, latchn_s;
  logic                   csn_fall, csn_rise, sclk_rise;

  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign latchn_s  = latchn_sync_q[SYNC_STAGES-1];
  assign csn_fall  = csn_prev_q & ~csn_s;
  assign csn_rise  = ~csn_prev_q & csn_s;
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  logic [15:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (csn_fall) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (!csn_s && sclk_rise) begin
      shift_d = {shift_q[14:0], mosi_s};
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 5'd1;
    end
  end

  // Two staging registers between the csn rise and the commit give the fixed
  // SYNC_STAGES+2 latency from pin to word_valid; the word is snapshotted at
  // the rise so a quick following frame cannot disturb it.
  logic        ev1_q, good1_q, ev2_q, good2_q;
  logic [15:0] word1_q, word2_q;

  logic [13:0] in_a_q, in_b_q, in_a_d, in_b_d;
  logic [13:0] o_a_q, o_b_q, o_a_d, o_b_d;
  logic        commit, commit_a, commit_b;
  logic        word_valid_q, frame_error_q;
  logic [15:0] word_data_q;

  assign commit   = ev2_q & good2_q;
  assign commit_a = commit & ~word2_q[15];
  assign commit_b = commit & word2_q[15];

  // Outputs load from the next-state input registers so a latch coinciding
  // with a commit picks up the new word instead of the stale one.
  always_comb begin
    in_a_d = commit_a ? word2_q[13:0] : in_a_q;
    in_b_d = commit_b ? word2_q[13:0] : in_b_q;
    o_a_d  = latchn_s ? o_a_q : in_a_d;
    o_b_d  = latchn_s ? o_b_q : in_b_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csn_sync_q    <= '1;
      sclk_sync_q   <= '0;
      mosi_sync_q   <= '0;
      latchn_sync_q <= '1;
      csn_prev_q    <= 1'b1;
      sclk_prev_q   <= 1'b0;
      shift_q       <= '0;
      cnt_q         <= '0;
      ev1_q         <= 1'b0;
      good1_q       <= 1'b0;
      word1_q       <= '0;
      ev2_q         <= 1'b0;
      good2_q       <= 1'b0;
      word2_q       <= '0;
      in_a_q        <= CH_RST;
      in_b_q        <= CH_RST;
      o_a_q         <= CH_RST;
      o_b_q         <= CH_RST;
      word_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      word_data_q   <= '0;
    end else begin
      csn_sync_q    <= {csn_sync_q[SYNC_STAGES-2:0], dac_csn};
      sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], dac_sclk};
      mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], dac_mosi};
      latchn_sync_q <= {latchn_sync_q[SYNC_STAGES-2:0], dac_latchn};
      csn_prev_q    <= csn_s;
      sclk_prev_q   <= sclk_s;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      ev1_q         <= csn_rise;
      good1_q       <= (cnt_q == CNT_WORD);
      word1_q       <= shift_q;
      ev2_q         <= ev1_q;
      good2_q       <= good1_q;
      word2_q       <= word1_q;
      in_a_q        <= in_a_d;
      in_b_q        <= in_b_d;
      o_a_q         <= o_a_d;
      o_b_q         <= o_b_d;
      word_valid_q  <= commit;
      frame_error_q <= ev2_q & ~good2_q;
      if (commit) word_data_q <= word2_q;
    end
  end

  assign out_a       = o_a_q[12] ? o_a_q[11:0] : 12'h000;
  assign out_b       = o_b_q[12] ? o_b_q[11:0] : 12'h000;
  assign active_a    = o_a_q[12];
  assign active_b    = o_b_q[12];
  assign gain_a      = o_a_q[13];
  assign gain_b      = o_b_q[13];
  assign word_valid  = word_valid_q;
  assign word_data   = word_data_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_dac_spi_receiver.sv
// tb/tb_dac_spi_receiver.sv - self-checking bench for dac_spi_receiver
module tb_dac_spi_receiver;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        dac_csn, dac_sclk, dac_mosi, dac_latchn;
  logic [11:0] out_a, out_b;
  logic        active_a, active_b, gain_a, gain_b;
  logic        word_valid, frame_error;
  logic [15:0] word_data;

  dac_spi_receiver #(.SYNC_STAGES(S), .WORD_BITS(16)) dut (
    .clk(clk), .reset(reset),
    .dac_csn(dac_csn), .dac_sclk(dac_sclk), .dac_mosi(dac_mosi), .dac_latchn(dac_latchn),
    .out_a(out_a), .out_b(out_b), .active_a(active_a), .active_b(active_b),
    .gain_a(gain_a), .gain_b(gain_b), .word_valid(word_valid),
    .word_data(word_data), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wv_cnt = 0;
  int fe_cnt = 0;

  always @(negedge clk) begin
    if (word_valid) wv_cnt++;
    if (frame_error) fe_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame with csn left low at the end
  task automatic frame_body(input logic [31:0] bits, input int n);
    dac_csn = 1'b0;
    cyc(4);
    for (int i = 0; i < n; i++) begin
      dac_mosi = bits[n-1-i];
      dac_sclk = 1'b0;
      cyc(4);
      dac_sclk = 1'b1;
      cyc(4);
    end
    dac_sclk = 1'b0;
    cyc(4);
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n);
    frame_body(bits, n);
    dac_csn = 1'b1;
    cyc(2 * S + 8);
  endtask

  task automatic pulse_latch();
    dac_latchn = 1'b0;
    cyc(4);
    dac_latchn = 1'b1;
    cyc(S + 4);
  endtask

  // Behavioural model: a channel's words sit in "pending" until latched
  logic [11:0] m_code_in[2], m_code_out[2];
  logic        m_ga_in[2], m_ga_out[2], m_sh_in[2], m_sh_out[2];
  logic [15:0] m_wd;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_code_in[c] = 0; m_code_out[c] = 0;
      m_ga_in[c] = 1;   m_ga_out[c] = 1;
      m_sh_in[c] = 0;   m_sh_out[c] = 0;
    end
    m_wd = 0;
  endtask

  task automatic model_frame(input logic [31:0] bits, input int n);
    int ch;
    if (n == 16) begin
      ch = int'(bits[15]);
      m_wd = bits[15:0];
      m_ga_in[ch]   = bits[13];
      m_sh_in[ch]   = bits[12];
      m_code_in[ch] = bits[11:0];
    end
  endtask

  task automatic model_latch();
    for (int c = 0; c < 2; c++) begin
      m_code_out[c] = m_code_in[c];
      m_ga_out[c] = m_ga_in[c];
      m_sh_out[c] = m_sh_in[c];
    end
  endtask

  typedef struct {
    logic [31:0] bits;
    int          nbits;   // 0 = no frame, latch only
    logic        latch;
    logic [11:0] eout_a;
    logic        eact_a, egain_a;
    logic [11:0] eout_b;
    logic        eact_b, egain_b;
    logic [15:0] ewd;
    int          ewv, efe;
  } vec_t;

  vec_t tbl[7];

  task automatic check_all(input string tag, input logic [11:0] ea, input logic aa, input logic ga,
                           input logic [11:0] eb, input logic ab, input logic gb, input logic [15:0] wd);
    chk({tag, ".out_a"}, out_a, ea);
    chk({tag, ".active_a"}, active_a, aa);
    chk({tag, ".gain_a"}, gain_a, ga);
    chk({tag, ".out_b"}, out_b, eb);
    chk({tag, ".active_b"}, active_b, ab);
    chk({tag, ".gain_b"}, gain_b, gb);
    chk({tag, ".word_data"}, word_data, wd);
  endtask

  initial begin
    int wv0, fe0, k, seen, n, lat;
    logic [31:0] bits;
    logic [11:0] prev_a;

    tbl[0] = '{32'h3ABC, 16, 1'b1, 12'hABC, 1'b1, 1'b1, 12'h000, 1'b0, 1'b1, 16'h3ABC, 1, 0};
    tbl[1] = '{32'hB123, 16, 1'b0, 12'hABC, 1'b1, 1'b1, 12'h000, 1'b0, 1'b1, 16'hB123, 1, 0};
    tbl[2] = '{32'h0,     0, 1'b1, 12'hABC, 1'b1, 1'b1, 12'h123, 1'b1, 1'b1, 16'hB123, 0, 0};
    tbl[3] = '{32'h3456, 12, 1'b1, 12'hABC, 1'b1, 1'b1, 12'h123, 1'b1, 1'b1, 16'hB123, 0, 1};
    tbl[4] = '{32'h3AAAA,20, 1'b1, 12'hABC, 1'b1, 1'b1, 12'h123, 1'b1, 1'b1, 16'hB123, 0, 1};
    tbl[5] = '{32'h2555, 16, 1'b1, 12'h000, 1'b0, 1'b1, 12'h123, 1'b1, 1'b1, 16'h2555, 1, 0};
    tbl[6] = '{32'h3555, 16, 1'b1, 12'h555, 1'b1, 1'b1, 12'h123, 1'b1, 1'b1, 16'h3555, 1, 0};

    reset = 1'b1; dac_csn = 1'b1; dac_sclk = 1'b0; dac_mosi = 1'b0; dac_latchn = 1'b1;
    cyc(3);
    check_all("reset", 12'h000, 0, 1, 12'h000, 0, 1, 16'h0000);
    chk("reset.word_valid", word_valid, 0);
    chk("reset.frame_error", frame_error, 0);
    reset = 1'b0;
    cyc(4);

    for (int i = 0; i < 7; i++) begin
      wv0 = wv_cnt; fe0 = fe_cnt;
      if (tbl[i].nbits != 0) send_frame(tbl[i].bits, tbl[i].nbits);
      if (tbl[i].latch) pulse_latch();
      check_all($sformatf("vec%0d", i), tbl[i].eout_a, tbl[i].eact_a, tbl[i].egain_a,
                tbl[i].eout_b, tbl[i].eact_b, tbl[i].egain_b, tbl[i].ewd);
      chk($sformatf("vec%0d.wv_count", i), wv_cnt - wv0, tbl[i].ewv);
      chk($sformatf("vec%0d.fe_count", i), fe_cnt - fe0, tbl[i].efe);
    end

    // Latch held low through the frame: output follows on the word_valid cycle,
    // which lands S+2 edges after the first edge seeing csn high.
    dac_latchn = 1'b0;
    cyc(S + 4);
    frame_body(32'h3777, 16);
    dac_csn = 1'b1;
    seen = 0;
    prev_a = out_a;
    for (k = 0; k < 20 && seen == 0; k++) begin
      @(posedge clk); #1;
      if (word_valid) begin
        seen = 1;
        chk("bypass.latency", k, S + 2);
        chk("bypass.out_a", out_a, 12'h777);
        chk("bypass.prev_out_a", prev_a, 12'h555);
        @(posedge clk); #1;
        chk("bypass.pulse_width", word_valid, 0);
      end
      prev_a = out_a;
    end
    chk("bypass.word_valid_seen", seen, 1);
    cyc(2);
    dac_latchn = 1'b1;
    cyc(S + 4);

    // Reset in the middle of a frame
    frame_body(32'hAB, 8);
    reset = 1'b1;
    dac_csn = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(4);
    wv0 = wv_cnt; fe0 = fe_cnt;
    cyc(2 * S + 8);
    chk("midreset.no_error", fe_cnt - fe0, 0);
    send_frame(32'hB0F0, 16);
    pulse_latch();
    check_all("midreset", 12'h000, 0, 1, 12'h0F0, 1, 1, 16'hB0F0);
    chk("midreset.wv_count", wv_cnt - wv0, 1);
    chk("midreset.fe_count", fe_cnt - fe0, 0);

    model_reset();
    model_frame(32'hB0F0, 16);
    model_latch();

    for (int r = 0; r < 24; r++) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
      bits = $urandom;
      lat = int'($urandom_range(0, 1));
      wv0 = wv_cnt; fe0 = fe_cnt;
      send_frame(bits, n);
      model_frame(bits, n);
      if (lat != 0) begin
        pulse_latch();
        model_latch();
      end
      check_all($sformatf("rnd%0d", r),
                m_sh_out[0] ? m_code_out[0] : 12'h000, m_sh_out[0], m_ga_out[0],
                m_sh_out[1] ? m_code_out[1] : 12'h000, m_sh_out[1], m_ga_out[1], m_wd);
      chk($sformatf("rnd%0d.wv_count", r), wv_cnt - wv0, (n == 16) ? 1 : 0);
      chk($sformatf("rnd%0d.fe_count", r), fe_cnt - fe0, (n == 16) ? 0 : 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
